nor_sweep_ctrl: RTL
===================

# nor_sweep_ctrl

Sequencer that exhaustively exercises a 2-input NOR datapath (`nor_gate`) in hardware. On `start` it drives all four `{a,b}` combinations onto the gate, waits a programmable settle time, samples the gate output and compares it with the expected NOR value. It reports pass/fail, a per-combination failure map and an error count. It sits between a top-level test/control interface and one `nor_gate` instance, and owns that instance's inputs exclusively.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..15.
- `ERR_W`, default 4: width of `err_count`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a run; honoured only in IDLE.
- `abort`  in  1  terminates a run; returns to IDLE on the next edge.
- `dut_y`  in  1  output of the controlled NOR gate.
- `dut_a`  out  1  NOR input a.
- `dut_b`  out  1  NOR input b.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse at normal completion.
- `pass`  out  1  result of last completed run; valid from `done` until next accepted `start`.
- `fail_vec`  out  4  sticky; bit k set if vector k ever mismatched during the run.
- `err_count`  out  ERR_W  total mismatches in the run, saturating at all-ones.

## Operation
- Vector index `idx` runs 0..3, with `dut_a = idx[1]` and `dut_b = idx[0]`. Expected value is `~(dut_a|dut_b)`, i.e. 1,0,0,0 for idx 0..3.
- FSM states:
  - IDLE: `busy=0`, `dut_a=dut_b=0`. `start` moves to DRIVE with idx=0, pass count=0, and clears `fail_vec`, `err_count` and `pass`.
  - DRIVE: holds the vector for SETTLE cycles using a down-counter, then moves to SAMPLE.
  - SAMPLE: one cycle. At its closing edge `dut_y` is compared with the expected value.
    - Mismatch sets `fail_vec[idx]` and increments `err_count`, saturating.
    - Any non-0/1 value on `dut_y` counts as a mismatch in simulation.
    - Next state: if idx<3, idx+1 and DRIVE. If idx==3 and more passes remain, idx=0, pass count+1, DRIVE. Otherwise DONE.
  - DONE: one cycle with `done=1` and `busy=0`. `pass` is set to (`err_count==0`), including the final sample. Then moves to IDLE.
- `abort` has priority over every other transition. From any non-IDLE state the FSM goes to IDLE on the next edge, with no `done` pulse, `pass=0`, and `fail_vec`/`err_count` frozen at their partial values.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE leave the FSM in IDLE.
- All outputs are registered.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): state IDLE, `dut_a=0`, `dut_b=0`, `busy=0`, `done=0`, `pass=0`, `fail_vec=0`, `err_count=0`.
- Reset mid-run aborts immediately with the same values. No `done` pulse follows.
- `start` is sampled at edge E0. `busy` and the first vector are driven from E0.
- Each vector occupies SETTLE+1 cycles. A run occupies N = 4·PASSES·(SETTLE+1) busy cycles.
- `busy` falls and `done` rises at edge E0+N. `done` falls at E0+N+1.
- Defaults (SETTLE=2, PASSES=1): N=12. Vector k is driven during cycles 3k..3k+2 after E0 and sampled at edge E0+3k+3.
- `dut_y` must be stable SETTLE cycles after a vector change. The controller never samples on the edge at which it changes a vector.
- A new `start` is accepted at the earliest in the IDLE cycle following DONE, i.e. edge E0+N+1.

## Test plan
- Correct `nor_gate` attached, defaults, start pulse → `busy` high for 12 cycles; `dut_a`/`dut_b` sequence 00,01,10,11; `done` at cycle 12; `pass=1`, `fail_vec=0000`, `err_count=0`.
- `dut_y` stuck at 0 → `pass=0`, `fail_vec=0001`, `err_count=1`.
- OR gate substituted (`dut_y=a|b`) with PASSES=2 → `fail_vec=1111`, `err_count=8`; `done` at cycle 24.
- ERR_W=2, PASSES=3, `dut_y` stuck at 1 → `err_count` saturates at 3, `fail_vec=1110`, `pass=0`.
- `abort` at cycle 5 after start → IDLE at the next edge; no `done`; `pass=0`; `fail_vec` and `err_count` keep their partial values. A `start` in the next IDLE cycle runs a clean full sweep.
- `rst_n` low at cycle 7 of a run, then `start` while busy on a fresh run → all outputs return to reset values immediately, and the `start` during busy has no effect on the sequence or the `done` timing.

Source files
------------

// File: rtl/nor_sweep_ctrl.sv
// nor_sweep_ctrl: drives all four {a,b} combinations onto a NOR gate,
// samples its output after a settle window and accumulates mismatches.
module nor_sweep_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PASSES = 1,
    parameter int unsigned ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_y,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_vec,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0]       CNT_LOAD  = 8'(SETTLE - 1);
    localparam logic [3:0]       LAST_PASS = 4'(PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_pass_cnt;
    logic             r_dut_a;
    logic             r_dut_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_fail_vec;
    logic [ERR_W-1:0] r_err_count;

    logic             w_exp;
    logic             w_mis;
    logic [3:0]       w_fail_nxt;
    logic [ERR_W-1:0] w_err_nxt;

    assign w_exp = ~(r_idx[1] | r_idx[0]);

    // Case equality so an undriven or X gate output is scored as a mismatch.
    assign w_mis = (dut_y === w_exp) ? 1'b0 : 1'b1;

    assign w_fail_nxt = r_fail_vec | (w_mis ? (4'b0001 << r_idx) : 4'b0000);

    assign w_err_nxt = (w_mis && (r_err_count != ERR_MAX))
                     ? r_err_count + 1'b1
                     : r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pass_cnt  <= '0;
            r_dut_a     <= 1'b0;
            r_dut_b     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_vec  <= '0;
            r_err_count <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state     <= S_DRIVE;
                        r_idx       <= 2'd0;
                        r_pass_cnt  <= 4'd0;
                        r_cnt       <= CNT_LOAD;
                        r_fail_vec  <= '0;
                        r_err_count <= '0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_dut_a     <= 1'b0;
                        r_dut_b     <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_dut_a <= 1'b0;
                        r_dut_b <= 1'b0;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_dut_a <= 1'b0;
                        r_dut_b <= 1'b0;
                    end else begin
                        r_fail_vec  <= w_fail_nxt;
                        r_err_count <= w_err_nxt;
                        if (r_idx != 2'd3) begin
                            r_idx              <= r_idx + 2'd1;
                            {r_dut_a, r_dut_b} <= r_idx + 2'd1;
                            r_cnt              <= CNT_LOAD;
                            r_state            <= S_DRIVE;
                        end else if (r_pass_cnt != LAST_PASS) begin
                            r_idx      <= 2'd0;
                            r_dut_a    <= 1'b0;
                            r_dut_b    <= 1'b0;
                            r_pass_cnt <= r_pass_cnt + 4'd1;
                            r_cnt      <= CNT_LOAD;
                            r_state    <= S_DRIVE;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                            r_dut_a <= 1'b0;
                            r_dut_b <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    if (abort) begin
                        r_pass <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_a     = r_dut_a;
    assign dut_b     = r_dut_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_vec  = r_fail_vec;
    assign err_count = r_err_count;

endmodule
